// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
//   Issue and writeback controller for the single-cycle FP unit
//   (add/sub/mul).
//
//   Request path:
//     Tagged operations arrive over a valid/ready handshake.
//     Dynamic rounding (rm == 7) is resolved against the current frm.
//     Illegal encodings are flagged here.
//     The operation is then registered into operand stage S1, which drives
//     the FPU inputs directly.
//
//   Response path:
//     When S1 advances, the FPU result and flags (or a zeroed "illegal"
//     record) are pushed into a 2-entry in-order FIFO.
//     The FIFO head is presented on resp_*.
//
//   Build option FPU_ISSUE_CSR_EN:
//     defined   : frm/fflags registers and the CSR write port are live.
//     undefined : CSR inputs are ignored, frm/fflags read as 0, and
//                 rm == 7 is treated as illegal.
//
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     req_valid/req_ready       request handshake
//     req_tag                   tag, returned with the response
//     req_ftype, req_rm         operation (0 add, 1 sub, 2 mul), rounding mode
//     req_frs1/2/3, req_rs      FP operands and integer operand
//     fu_frs1/2/3, fu_rs        FPU operands (from S1)
//     fu_ftype, fu_rm           FPU operation and resolved rounding mode (from S1)
//     fu_control                tininess detection mode
//     fu_res, fu_flags          FPU result and flags (bit 5 unused)
//     resp_valid/resp_ready     response handshake
//     resp_tag, resp_data       FIFO head: tag and result
//     resp_flags, resp_illegal  FIFO head: flags and illegal bit
//     csr_we, csr_wdata         write of {frm, fflags}
//     frm, fflags               architectural rounding mode and sticky flags
module fpu_issue_ctrl #(
  parameter int   EXPWIDTH = 8,
  parameter int   SIGWIDTH = 24,
  parameter int   XLEN     = 32,
  parameter int   FLEN     = EXPWIDTH + SIGWIDTH,
  parameter int   TAGW     = 4,
  parameter logic TININESS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [TAGW-1:0] req_tag,
  input  logic [4:0]      req_ftype,
  input  logic [2:0]      req_rm,
  input  logic [FLEN-1:0] req_frs1,
  input  logic [FLEN-1:0] req_frs2,
  input  logic [FLEN-1:0] req_frs3,
  input  logic [XLEN-1:0] req_rs,
  output logic [FLEN-1:0] fu_frs1,
  output logic [FLEN-1:0] fu_frs2,
  output logic [FLEN-1:0] fu_frs3,
  output logic [XLEN-1:0] fu_rs,
  output logic [4:0]      fu_ftype,
  output logic [2:0]      fu_rm,
  output logic            fu_control,
  input  logic [FLEN-1:0] fu_res,
  input  logic [5:0]      fu_flags,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [TAGW-1:0] resp_tag,
  output logic [FLEN-1:0] resp_data,
  output logic [4:0]      resp_flags,
  output logic            resp_illegal,
  input  logic            csr_we,
  input  logic [7:0]      csr_wdata,
  output logic [2:0]      frm,
  output logic [4:0]      fflags
);

  // S1 operand stage
  logic            s1_v_q, s1_v_d;
  logic [TAGW-1:0] s1_tag_q;
  logic [4:0]      s1_ftype_q;
  logic [2:0]      s1_rm_q;
  logic [FLEN-1:0] s1_frs1_q, s1_frs2_q, s1_frs3_q;
  logic [XLEN-1:0] s1_rs_q;
  logic            s1_ill_q;

  // Response FIFO storage and pointers
  logic [TAGW-1:0] fifo_tag_q  [2];
  logic [FLEN-1:0] fifo_data_q [2];
  logic [4:0]      fifo_flags_q[2];
  logic            fifo_ill_q  [2];
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [1:0]      count_q, count_d;

  logic       req_fire, s1_fire, resp_fire;
  logic [2:0] rm_resolved;
  logic       req_illegal;

  // Handshake glue: S1 may move into the FIFO when there is room,
  // or when the head leaves in the same cycle.
  assign resp_valid  = (count_q != 2'd0);
  assign resp_fire   = resp_valid & resp_ready;
  assign s1_fire     = s1_v_q & ((count_q < 2'd2) | resp_fire);
  assign req_ready   = ~s1_v_q | s1_fire;
  assign req_fire    = req_valid & req_ready;
  assign req_illegal = (req_ftype > 5'd2) | (rm_resolved >= 3'd5);

`ifdef FPU_ISSUE_CSR_EN
  logic [2:0] frm_q, frm_d;
  logic [4:0] fflags_q, fflags_d;
  logic       unused_flag5;

  assign unused_flag5 = fu_flags[5];
  assign rm_resolved  = (req_rm == 3'd7) ? frm_q : req_rm;
  assign frm          = frm_q;
  assign fflags       = fflags_q;

  // A CSR write replaces fflags; flags of a same-cycle legal enqueue
  // are ORed on top. A request accepted alongside a frm write still
  // sees the old frm, because it reads frm_q.
  always_comb begin
    frm_d    = csr_we ? csr_wdata[7:5] : frm_q;
    fflags_d = csr_we ? csr_wdata[4:0] : fflags_q;
    if (s1_fire && !s1_ill_q) begin
      fflags_d = fflags_d | fu_flags[4:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frm_q    <= '0;
      fflags_q <= '0;
    end else begin
      frm_q    <= frm_d;
      fflags_q <= fflags_d;
    end
  end
`else
  logic unused_csr;

  // Without CSR state, rm == 7 stays 7 and is therefore illegal.
  assign unused_csr  = ^{csr_we, csr_wdata, fu_flags[5]};
  assign rm_resolved = req_rm;
  assign frm         = '0;
  assign fflags      = '0;
`endif

  // S1 loads only on accept. It otherwise holds, which keeps the fu_*
  // outputs stable under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_tag_q   <= '0;
      s1_ftype_q <= '0;
      s1_rm_q    <= '0;
      s1_frs1_q  <= '0;
      s1_frs2_q  <= '0;
      s1_frs3_q  <= '0;
      s1_rs_q    <= '0;
      s1_ill_q   <= 1'b0;
    end else if (req_fire) begin
      s1_tag_q   <= req_tag;
      s1_ftype_q <= req_ftype;
      s1_rm_q    <= rm_resolved;
      s1_frs1_q  <= req_frs1;
      s1_frs2_q  <= req_frs2;
      s1_frs3_q  <= req_frs3;
      s1_rs_q    <= req_rs;
      s1_ill_q   <= req_illegal;
    end
  end

  // Occupancy and pointer bookkeeping for S1 and the FIFO.
  always_comb begin
    s1_v_d   = s1_v_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (req_fire) begin
      s1_v_d = 1'b1;
    end else if (s1_fire) begin
      s1_v_d = 1'b0;
    end
    if (s1_fire) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (resp_fire) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, s1_fire} - {1'b0, resp_fire};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO write.
  // When full, a push only happens together with a pop, and then
  // wr_ptr equals rd_ptr: the slot being overwritten is the one leaving.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_tag_q[i]   <= '0;
        fifo_data_q[i]  <= '0;
        fifo_flags_q[i] <= '0;
        fifo_ill_q[i]   <= 1'b0;
      end
    end else if (s1_fire) begin
      fifo_tag_q[wr_ptr_q]   <= s1_tag_q;
      fifo_data_q[wr_ptr_q]  <= s1_ill_q ? '0 : fu_res;
      fifo_flags_q[wr_ptr_q] <= s1_ill_q ? 5'b0 : fu_flags[4:0];
      fifo_ill_q[wr_ptr_q]   <= s1_ill_q;
    end
  end

  assign resp_tag     = fifo_tag_q[rd_ptr_q];
  assign resp_data    = fifo_data_q[rd_ptr_q];
  assign resp_flags   = fifo_flags_q[rd_ptr_q];
  assign resp_illegal = fifo_ill_q[rd_ptr_q];

  assign fu_frs1    = s1_frs1_q;
  assign fu_frs2    = s1_frs2_q;
  assign fu_frs3    = s1_frs3_q;
  assign fu_rs      = s1_rs_q;
  assign fu_ftype   = s1_ftype_q;
  assign fu_rm      = s1_rm_q;
  assign fu_control = TININESS;

endmodule
